bias_out_axis_packer: RTL and testbench
=======================================

Name: bias_out_axis_packer

Overview:
Terminal consumer of the bias-add output stream in the MAC → adapter → bias-add pipeline. Accepts one TILE_SIZE-lane vector per valid/ready handshake and packs PACK consecutive vectors into one OUT_W-bit word. Emits packed words on an AXI4-Stream master port, asserting TLAST on the final word of each D-element output vector. It is the transmit-side counterpart of the tile-start AXIS slave at the front of the pipeline.

Parameters:
TILE_SIZE, 4, lanes per input vector
DATA_WIDTH, 16, bits per lane (signed Q-format, passed through unchanged)
PACK, 4, input beats per output word
D, 256, elements per output vector (frame); must be a multiple of TILE_SIZE*PACK
OUT_W, PACK*TILE_SIZE*DATA_WIDTH (256), output word width
WORDS, D/(TILE_SIZE*PACK) (16), output words per frame

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid (driven by bias_out_valid)
in_ready  out  1  input ready (drives bias_out_ready)
in_vec  in  TILE_SIZE x DATA_WIDTH signed  input lanes, [i] = lane i
m_axis_TVALID  out  1  output word valid
m_axis_TREADY  in  1  downstream ready
m_axis_TDATA  out  OUT_W  packed word
m_axis_TLAST  out  1  last word of frame
frame_done  out  1  one-cycle pulse after the TLAST word fires
word_cnt  out  $clog2(WORDS)  index of the next word to be emitted in the frame

Behaviour:
- Reset (asynchronous, rst_n=0): slot_cnt=0, gather=0, m_axis_TVALID=0, m_axis_TDATA=0, m_axis_TLAST=0, frame_done=0, word_cnt=0, in_ready=0 while rst_n=0. in_ready goes to 1 in the first cycle after release.
- Reset mid-operation discards any partial gather and any held output word. No output is emitted from pre-reset beats.
- in_fire = in_valid & in_ready. out_fire = m_axis_TVALID & m_axis_TREADY.
- Storage: gather register (PACK slots) plus one output register.
- slot_cnt ranges 0..PACK. The value PACK means FULL.
- in_ready = (slot_cnt != PACK). It is a combinational function of registered state only.
- Packing: beat k (0-based within the word) lane i is placed at TDATA[(k*TILE_SIZE+i)*DATA_WIDTH +: DATA_WIDTH]. No arithmetic, no saturation; bits are copied verbatim.
- in_fire with slot_cnt < PACK-1: write slot slot_cnt, then slot_cnt += 1.
- in_fire with slot_cnt == PACK-1 (closing beat):
  - If out_free = (!m_axis_TVALID | out_fire): load the output register directly with {in_vec, gather slots 0..PACK-2}, set TVALID=1, set TLAST=(word_cnt==WORDS-1), set slot_cnt=0.
  - Otherwise: write the slot and set slot_cnt=PACK (FULL).
- FULL & out_free: transfer gather → output register, set TVALID=1, set TLAST per word_cnt, set slot_cnt=0.
- Latency: closing beat accepted at cycle t → TVALID is high at t+1 when the output is free. If the output was blocked, TVALID is high one cycle after out_free.
- Throughput: sustained 1 input beat/cycle with TREADY=1, giving 1 word every PACK cycles and no bubbles.
- out_fire without a simultaneous load: TVALID=0, TLAST=0.
- TDATA and TLAST hold stable while TVALID=1 & TREADY=0. TVALID never drops without out_fire.
- word_cnt increments on out_fire and wraps WORDS-1 → 0. Frames repeat back-to-back with no gap.
- frame_done=1 in the cycle after out_fire with TLAST=1; otherwise 0.
- Simultaneous load and out_fire in the same cycle: the old word is consumed and the new word is registered. TVALID stays 1.
- Backpressure with TREADY=0 indefinitely: at most PACK + PACK beats are accepted (output register plus full gather), then in_ready=0.

Test Plan:
- Streaming: 64 beats, beat n lanes = 1000+4n+i, TREADY=1 → 16 words; word w lane j = 1000+16w+j. TLAST only on w=15. frame_done pulses once, one cycle after word 15. No in_ready drop.
- Latency: single word with beats on cycles 0..3 → TVALID first high at cycle 4. TDATA[15:0]=first beat lane0 and TDATA[255:240]=fourth beat lane3.
- Stall: TREADY=0 from start, 12 beats offered every cycle → exactly 8 accepted, then in_ready=0. Word 0 TDATA is stable throughout. Release TREADY → words 0,1 emitted in order, remaining 4 beats accepted, word 2 correct.
- Simultaneous: TREADY toggling 1/0 each cycle with continuous input → TDATA never changes while TVALID=1 & TREADY=0. All 16 words match the expected values. word_cnt wraps to 0 after frame 1; frame 2 TLAST again on its 16th word.
- Reset mid-frame: assert rst_n=0 after 6 beats, TREADY=0 → TVALID=0 and in_ready=0 immediately. After release, 64 fresh beats → 16 words matching the fresh data only, with no stale lanes.
- Signed pass-through: lanes = -1 (0xFFFF) and -32768 (0x8000) → identical bit patterns in TDATA with no sign-extension bleed between lanes.

Source files
------------

// File: rtl/bias_out_axis_packer.sv
// Packs PACK consecutive bias-add output vectors into one wide AXI4-Stream word,
// with TLAST marking the final word of each D-element frame.
module bias_out_axis_packer #(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int PACK       = 4,
    parameter int D          = 256,
    parameter int OUT_W      = PACK * TILE_SIZE * DATA_WIDTH,
    parameter int WORDS      = D / (TILE_SIZE * PACK)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] in_vec,
    output logic                            m_axis_TVALID,
    input  logic                            m_axis_TREADY,
    output logic [OUT_W-1:0]                m_axis_TDATA,
    output logic                            m_axis_TLAST,
    output logic                            frame_done,
    output logic [$clog2(WORDS)-1:0]        word_cnt
);

    localparam int VEC_W = TILE_SIZE * DATA_WIDTH;
    localparam int SW    = $clog2(PACK + 1);
    localparam int WW    = $clog2(WORDS);
    localparam logic [SW-1:0] SLOT_FULL = SW'(PACK);
    localparam logic [SW-1:0] SLOT_LAST = SW'(PACK - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);

    logic [SW-1:0]    slot_cnt;
    logic [OUT_W-1:0] gather;
    logic             ready_en;

    logic             in_fire;
    logic             out_fire;
    logic             out_free;
    logic             load_direct;
    logic             load_full;
    logic             load;
    logic [OUT_W-1:0] load_word;
    logic [WW-1:0]    word_next;
    logic [WW-1:0]    load_idx;

    // ready_en keeps in_ready low throughout reset and for the release cycle
    assign in_ready    = ready_en && (slot_cnt != SLOT_FULL);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = m_axis_TVALID && m_axis_TREADY;
    assign out_free    = !m_axis_TVALID || out_fire;
    assign load_direct = in_fire && (slot_cnt == SLOT_LAST) && out_free;
    assign load_full   = (slot_cnt == SLOT_FULL) && out_free;
    assign load        = load_direct || load_full;
    assign word_next   = (word_cnt == WORD_LAST) ? '0 : word_cnt + WW'(1);
    // A word loaded while the old one leaves takes the following frame index
    assign load_idx    = out_fire ? word_next : word_cnt;

    always_comb begin
        load_word = gather;
        if (load_direct) begin
            load_word[(PACK-1)*VEC_W +: VEC_W] = in_vec;
        end
    end

    // A blocked closing beat is stored and the count steps on to FULL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            gather   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (load_full) begin
                slot_cnt <= '0;
            end else if (in_fire) begin
                if (load_direct) begin
                    slot_cnt <= '0;
                end else begin
                    for (int k = 0; k < PACK; k++) begin
                        if (slot_cnt == SW'(k)) begin
                            gather[k*VEC_W +: VEC_W] <= in_vec;
                        end
                    end
                    slot_cnt <= slot_cnt + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_TVALID <= 1'b0;
            m_axis_TDATA  <= '0;
            m_axis_TLAST  <= 1'b0;
            frame_done    <= 1'b0;
            word_cnt      <= '0;
        end else begin
            frame_done <= out_fire && m_axis_TLAST;
            if (out_fire) begin
                word_cnt <= word_next;
            end
            if (load) begin
                m_axis_TVALID <= 1'b1;
                m_axis_TDATA  <= load_word;
                m_axis_TLAST  <= (load_idx == WORD_LAST);
            end else if (out_fire) begin
                m_axis_TVALID <= 1'b0;
                m_axis_TLAST  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bias_out_axis_packer.sv
// Directed self-checking bench for bias_out_axis_packer: streaming, latency,
// backpressure, toggled TREADY, mid-frame reset and signed pass-through.
module tb_bias_out_axis_packer;

    logic         clk;
    logic         rst_n;
    logic         inValid;
    logic         in_ready;
    logic [63:0]  inVec;
    logic         m_axis_TVALID;
    logic         tready;
    logic [255:0] m_axis_TDATA;
    logic         m_axis_TLAST;
    logic         frame_done;
    logic [3:0]   word_cnt;

    int checkCount = 0;
    int passCount  = 0;

    bias_out_axis_packer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (inValid),
        .in_ready     (in_ready),
        .in_vec       (inVec),
        .m_axis_TVALID(m_axis_TVALID),
        .m_axis_TREADY(tready),
        .m_axis_TDATA (m_axis_TDATA),
        .m_axis_TLAST (m_axis_TLAST),
        .frame_done   (frame_done),
        .word_cnt     (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] makeBeat(input int n, input int base);
        logic [63:0] b;
        for (int i = 0; i < 4; i++) b[i*16 +: 16] = 16'(base + 4*n + i);
        return b;
    endfunction

    function automatic logic [255:0] makeWord(input int w, input int base);
        logic [255:0] d;
        for (int j = 0; j < 16; j++) d[j*16 +: 16] = 16'(base + 16*w + j);
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checkCount = checkCount + 1;
        assert (obs === exp) passCount = passCount + 1;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge
    task automatic applyStimulus(input logic v, input logic [63:0] vec, input logic rdy);
        inValid = v;
        inVec   = vec;
        tready  = rdy;
        @(negedge clk);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst_n   = 1'b0;
        inValid = 1'b0;
        inVec   = '0;
        tready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nextCycle();
    endtask

    // Model: beat n lane i = base+4n+i, so word w lane j = base+16w+j
    task automatic runStream(input int base, input int nBeats, input int nWords,
                             input int stallCycles, input bit toggle,
                             input int cycles, input int expDone);
        int   beatN;
        int   wordN;
        int   doneCnt;
        bit   prevLastFire;
        logic rdy;
        logic v;
        beatN = 0;
        wordN = 0;
        doneCnt = 0;
        prevLastFire = 1'b0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            rdy = (cyc >= stallCycles) && (!toggle || (cyc % 2 == 0));
            v   = (beatN < nBeats);
            applyStimulus(v, makeBeat(beatN, base), rdy);
            if (stallCycles > 0 && cyc == stallCycles) begin
                checkOutput("stall_accepted", beatN, 8);
                checkOutput("stall_in_ready", in_ready, 1'b0);
            end
            if (stallCycles == 0 && !toggle && v)
                checkOutput("stream_in_ready", in_ready, 1'b1);
            checkOutput("frame_done", frame_done, prevLastFire);
            if (frame_done) doneCnt++;
            prevLastFire = 1'b0;
            if (m_axis_TVALID) begin
                checkOutput("tdata", m_axis_TDATA, makeWord(wordN, base));
                checkOutput("tlast", m_axis_TLAST, (wordN % 16 == 15));
                checkOutput("word_cnt", word_cnt, wordN % 16);
                if (rdy) begin
                    prevLastFire = (wordN % 16 == 15);
                    wordN++;
                end
            end
            if (v && in_ready) beatN++;
            nextCycle();
        end
        checkOutput("beats_accepted", beatN, nBeats);
        checkOutput("words_emitted", wordN, nWords);
        checkOutput("frame_done_count", doneCnt, expDone);
    endtask

    initial begin
        rst_n   = 1'b0;
        inValid = 1'b0;
        inVec   = '0;
        tready  = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        checkOutput("rst_tvalid", m_axis_TVALID, 1'b0);
        checkOutput("rst_tdata", m_axis_TDATA, '0);
        checkOutput("rst_tlast", m_axis_TLAST, 1'b0);
        checkOutput("rst_frame_done", frame_done, 1'b0);
        checkOutput("rst_word_cnt", word_cnt, 4'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("post_rst_in_ready", in_ready, 1'b1);
        nextCycle();

        // Full-rate streaming frame
        runStream(1000, 64, 16, 0, 1'b0, 80, 1);

        // Latency of a single word: beats on cycles 0..3, TVALID at cycle 4
        resetDut();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(c < 4, makeBeat(c, 2000), 1'b0);
            checkOutput("lat_tvalid", m_axis_TVALID, (c == 4));
            if (c < 4) checkOutput("lat_in_ready", in_ready, 1'b1);
            if (c == 4) begin
                checkOutput("lat_lane_first", m_axis_TDATA[15:0], 16'd2000);
                checkOutput("lat_lane_last", m_axis_TDATA[255:240], 16'd2015);
                checkOutput("lat_word", m_axis_TDATA, makeWord(0, 2000));
            end
            nextCycle();
        end

        // Backpressure: 14 stalled cycles, then release
        resetDut();
        runStream(3000, 12, 3, 14, 1'b0, 40, 0);

        // Toggling TREADY across two frames
        resetDut();
        runStream(6000, 128, 32, 0, 1'b1, 160, 2);

        // Reset with a held word and a partial gather
        resetDut();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, makeBeat(c, 4000), 1'b0);
            nextCycle();
        end
        checkOutput("pre_rst_tvalid", m_axis_TVALID, 1'b1);
        rst_n   = 1'b0;
        inValid = 1'b0;
        #1;
        checkOutput("mid_rst_tvalid", m_axis_TVALID, 1'b0);
        checkOutput("mid_rst_in_ready", in_ready, 1'b0);
        checkOutput("mid_rst_tdata", m_axis_TDATA, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nextCycle();
        runStream(5000, 64, 16, 0, 1'b0, 80, 1);

        // Signed lanes copied verbatim
        resetDut();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 64'h8000FFFF8000FFFF, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("signed_tvalid", m_axis_TVALID, 1'b1);
        checkOutput("signed_tdata", m_axis_TDATA, {8{32'h8000FFFF}});

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
